// File: rtl/queue_pkg.sv
// Shared types and width helpers for stage_queue instances.
// Widths are functions of DEPTH/LANES so every instance derives its own typedefs.
package queue_pkg;

    localparam int QUEUE_MAX_LANES = 4;

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int pop_bits(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    function automatic int popcount_lanes(input logic [QUEUE_MAX_LANES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < QUEUE_MAX_LANES; i++) begin
            if (v[i]) n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/stage_queue_if.sv
// Producer/consumer handshake bundle of a stage_queue.
// slave = queue side, master = surrounding pipeline side.
interface stage_queue_if
    import queue_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) ();

    localparam int POP_W = pop_bits(LANES);
    localparam int CNT_W = cnt_bits(DEPTH);

    logic                    flush;
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_ready;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;
    logic [POP_W-1:0]        out_pop;
    logic [CNT_W-1:0]        count;

    modport slave (
        input  flush, in_valid, in_data, out_pop,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output flush, in_valid, in_data, out_pop,
        input  in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/lane_compact.sv
// Packs sparse valid lanes into ascending slots 0..n-1 and reports n.
// Purely combinational; feeds both the storage write port and the bypass path.
module lane_compact
    import queue_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 64
) (
    input  logic [LANES-1:0]          i_valid,
    input  logic [LANES*DATA_W-1:0]   i_data,
    output logic [LANES-1:0]          o_valid,
    output logic [LANES*DATA_W-1:0]   o_data,
    output logic [pop_bits(LANES)-1:0] o_cnt
);

    localparam int CW = pop_bits(LANES);

    always_comb begin
        int pre;
        // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
        o_data  = '0;
        o_valid = '0;
        pre     = 0;
        for (int i = 0; i < LANES; i++) begin
            // Lane i lands in the slot equal to the number of valid lanes below it.
            for (int j = 0; j < LANES; j++) begin
                if (i_valid[i] && (pre == j)) o_data[j*DATA_W +: DATA_W] = i_data[i*DATA_W +: DATA_W];
            end
            if (i_valid[i]) pre = pre + 1;
        end
        for (int j = 0; j < LANES; j++) begin
            o_valid[j] = (pre > j);
        end
        o_cnt = CW'(popcount_lanes(QUEUE_MAX_LANES'(i_valid)));
    end

endmodule

// File: rtl/stage_queue.sv
// Multi-lane decoupling queue between in-order front-end stages.
// Optional zero-latency pass-through when empty: define STAGE_QUEUE_BYPASS_EN.
module stage_queue
    import queue_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    stage_queue_if.slave q
);

    localparam int PTR_W = ptr_bits(DEPTH);
    localparam int CNT_W = cnt_bits(DEPTH);
    localparam int POP_W = pop_bits(LANES);
    localparam int SUM_W = CNT_W + 1;

    typedef logic [PTR_W-1:0] qptr_t;
    typedef logic [CNT_W-1:0] qcnt_t;
    typedef logic [SUM_W-1:0] qsum_t;

    qptr_t             r_head;
    qptr_t             r_tail;
    qcnt_t             r_count;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [LANES-1:0]        w_cvalid;
    logic [LANES*DATA_W-1:0] w_cdata;
    logic [POP_W-1:0]        w_ccnt;
    logic                    w_in_ready;
    logic                    w_push_ok;
    logic                    w_bypass;
    qsum_t                   w_push_n;
    qsum_t                   w_avail;
    qsum_t                   w_pop_req;
    qsum_t                   w_pop;
    qsum_t                   w_skip;
    qsum_t                   w_push_store;
    qsum_t                   w_pop_store;
    logic [LANES-1:0]        w_wr_en;
    qptr_t                   w_wr_ptr [LANES];
    logic [LANES-1:0]        w_thermo;
    logic [LANES*DATA_W-1:0] w_rdata;

    lane_compact #(.LANES(LANES), .DATA_W(DATA_W)) u_compact (
        .i_valid (q.in_valid),
        .i_data  (q.in_data),
        .o_valid (w_cvalid),
        .o_data  (w_cdata),
        .o_cnt   (w_ccnt)
    );

    // Ready looks only at registered occupancy: no consumer->producer combinational path.
    assign w_in_ready = (qsum_t'(DEPTH) - qsum_t'(r_count)) >= qsum_t'(LANES);
    assign w_push_ok  = w_in_ready && !q.flush;

`ifdef STAGE_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && !q.flush;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_push_n     = w_push_ok ? qsum_t'(w_ccnt) : '0;
        w_avail      = qsum_t'(r_count) + (w_bypass ? w_push_n : '0);
        w_pop_req    = qsum_t'(q.out_pop);
        w_pop        = (w_pop_req > w_avail) ? w_avail : w_pop_req;
        // Lanes consumed straight off the bypass never touch storage.
        w_skip       = w_bypass ? w_pop : '0;
        w_pop_store  = w_pop - w_skip;
        w_push_store = w_push_n - w_skip;
        for (int j = 0; j < LANES; j++) begin
            w_wr_en[j]  = (qsum_t'(j) >= w_skip) && (qsum_t'(j) < w_push_n);
            w_wr_ptr[j] = r_tail + qptr_t'(qsum_t'(j) - w_skip);
        end
    end

    always_comb begin
        w_thermo = '0;
        w_rdata  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_thermo[i] = (qsum_t'(r_count) > qsum_t'(i));
            w_rdata[i*DATA_W +: DATA_W] = r_mem[r_head + qptr_t'(i)];
        end
    end

    assign q.in_ready  = w_in_ready;
    assign q.out_valid = w_bypass ? w_cvalid : w_thermo;
    assign q.out_data  = w_bypass ? w_cdata : w_rdata;
    assign q.count     = r_count;

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + qptr_t'(w_pop_store);
            r_tail  <= r_tail + qptr_t'(w_push_store);
            r_count <= qcnt_t'(qsum_t'(r_count) + w_push_store - w_pop_store);
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (w_wr_en[j]) r_mem[w_wr_ptr[j]] <= w_cdata[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (w_pop_req <= w_avail)
            else $error("stage_queue: out_pop exceeds available entries");
        end
    end

endmodule

// File: tb/tb_stage_queue.sv
// Directed bench for stage_queue (LANES=2, DEPTH=8) with a queue-level reference model.
// Follows STAGE_QUEUE_BYPASS_EN the same way the design does.
module tb_stage_queue;

    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;

    typedef logic [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stage_queue_if #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) qif ();

    stage_queue #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (qif)
    );

    int    n_vec = 0;
    int    n_err = 0;
    bit    cmp_en = 1'b0;
    word_t mq[$];

    logic        smp_ready;
    logic [1:0]  smp_valid;
    logic [3:0]  smp_cnt;
    word_t       smp_d0;
    word_t       smp_d1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: plain FIFO of words, updated once per clock.
    always @(posedge clk) begin
        word_t comp[$];
        int    pop;
        bit    rdy;
        if (reset || qif.flush) begin
            mq.delete();
        end else begin
            comp.delete();
            for (int i = 0; i < LANES; i++)
                if (qif.in_valid[i]) comp.push_back(qif.in_data[i*DATA_W +: DATA_W]);
            rdy = (DEPTH - mq.size()) >= LANES;
            pop = int'(qif.out_pop);
`ifdef STAGE_QUEUE_BYPASS_EN
            if (mq.size() == 0) begin
                if (pop > comp.size()) pop = comp.size();
                for (int k = 0; k < pop; k++) void'(comp.pop_front());
                mq = comp;
            end else
`endif
            begin
                if (pop > mq.size()) pop = mq.size();
                for (int k = 0; k < pop; k++) void'(mq.pop_front());
                if (rdy) foreach (comp[k]) mq.push_back(comp[k]);
            end
        end
    end

    // Compare process: DUT outputs against the model on every non-reset cycle.
    always @(negedge clk) begin
        word_t vis[$];
        bit    ev;
        if (cmp_en && !reset) begin
            vis = mq;
`ifdef STAGE_QUEUE_BYPASS_EN
            if (mq.size() == 0 && !qif.flush)
                for (int i = 0; i < LANES; i++)
                    if (qif.in_valid[i]) vis.push_back(qif.in_data[i*DATA_W +: DATA_W]);
`endif
            check("model_in_ready", 64'(qif.in_ready), 64'((DEPTH - mq.size()) >= LANES));
            check("model_count", 64'(qif.count), 64'(mq.size()));
            for (int i = 0; i < LANES; i++) begin
                ev = (vis.size() > i);
                check("model_out_valid", 64'(qif.out_valid[i]), 64'(ev));
                if (ev) check("model_out_data", qif.out_data[i*DATA_W +: DATA_W], vis[i]);
            end
        end
    end

    task automatic step(input logic [1:0] v, input word_t d0, input word_t d1, input int pop, input bit fl);
        qif.in_valid = v;
        qif.in_data  = {d1, d0};
        qif.out_pop  = 2'(pop);
        qif.flush    = fl;
        @(negedge clk);
        smp_ready = qif.in_ready;
        smp_valid = qif.out_valid;
        smp_cnt   = qif.count;
        smp_d0    = qif.out_data[0 +: DATA_W];
        smp_d1    = qif.out_data[DATA_W +: DATA_W];
        @(posedge clk);
        #1;
        qif.in_valid = '0;
        qif.in_data  = '0;
        qif.out_pop  = '0;
        qif.flush    = 1'b0;
    endtask

    task automatic idle();
        step(2'b00, '0, '0, 0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        word_t got[$];
        word_t wa = 64'hAAAA_0000_0000_000A;
        word_t wb = 64'hBBBB_0000_0000_000B;
        word_t wc = 64'hCCCC_0000_0000_000C;
        word_t wd = 64'hD000_0000_0000_0000;

        reset = 1'b1;
        qif.in_valid = '0;
        qif.in_data  = '0;
        qif.out_pop  = '0;
        qif.flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        idle();
        check("reset_in_ready", 64'(smp_ready), 64'(1));
        check("reset_out_valid", 64'(smp_valid), 64'(0));
        check("reset_count", 64'(smp_cnt), 64'(0));

        // Full-group push, visible next cycle with lane0 = A
        step(2'b11, wa, wb, 0, 1'b0);
        idle();
        check("push2_valid", 64'(smp_valid), 64'(2'b11));
        check("push2_lane0", smp_d0, wa);
        check("push2_lane1", smp_d1, wb);
        check("push2_count", 64'(smp_cnt), 64'(2));

        // Sparse lane1-only push compacts to one entry, surfaces on lane0 once A,B are gone
        step(2'b10, '0, wc, 0, 1'b0);
        idle();
        check("sparse_count", 64'(smp_cnt), 64'(3));
        step(2'b00, '0, '0, 2, 1'b0);
        idle();
        check("sparse_head", smp_d0, wc);
        check("sparse_valid", 64'(smp_valid), 64'(2'b01));

        // Fill to 7: not ready; a push alongside a pop of 2 is dropped
        for (int k = 0; k < 3; k++) step(2'b11, wd + word_t'(2*k), wd + word_t'(2*k+1), 0, 1'b0);
        idle();
        check("fill7_count", 64'(smp_cnt), 64'(7));
        check("fill7_ready", 64'(smp_ready), 64'(0));
        step(2'b11, 64'hEEEE, 64'hFFFF, 2, 1'b0);
        idle();
        check("stall_count", 64'(smp_cnt), 64'(5));
        check("stall_ready", 64'(smp_ready), 64'(1));
        check("stall_head", smp_d0, wd + 64'd1);
        step(2'b00, '0, '0, 2, 1'b0);
        step(2'b00, '0, '0, 2, 1'b0);
        step(2'b00, '0, '0, 1, 1'b0);
        idle();
        check("drain_count", 64'(smp_cnt), 64'(0));

        // Wrap: 20 cycles of push 2 / pop 2 with data 0..39
        for (int k = 0; k < 20; k++) begin
            step(2'b11, word_t'(2*k), word_t'(2*k+1), (k > 0) ? 2 : 0, 1'b0);
            if (k > 0) begin
                got.push_back(smp_d0);
                got.push_back(smp_d1);
                check("wrap_count", 64'(smp_cnt), 64'(2));
            end
        end
        step(2'b00, '0, '0, 2, 1'b0);
        got.push_back(smp_d0);
        got.push_back(smp_d1);
        check("wrap_total", 64'(got.size()), 64'(40));
        foreach (got[i]) check("wrap_order", got[i], 64'(i));

        // Flush at count 6 beats a same-cycle push and pop
        for (int k = 0; k < 3; k++) step(2'b11, 64'h600 + word_t'(k), 64'h700 + word_t'(k), 0, 1'b0);
        idle();
        check("pre_flush_count", 64'(smp_cnt), 64'(6));
        step(2'b11, 64'h999, 64'h998, 1, 1'b1);
        idle();
        check("flush_count", 64'(smp_cnt), 64'(0));
        check("flush_valid", 64'(smp_valid), 64'(0));

        // Exactly full
        for (int k = 0; k < 4; k++) step(2'b11, 64'h800 + word_t'(k), 64'h900 + word_t'(k), 0, 1'b0);
        idle();
        check("full_count", 64'(smp_cnt), 64'(8));
        check("full_ready", 64'(smp_ready), 64'(0));
        check("full_head", smp_d0, 64'h800);
        step(2'b00, '0, '0, 0, 1'b1);
        idle();
        check("full_flush_count", 64'(smp_cnt), 64'(0));

`ifdef STAGE_QUEUE_BYPASS_EN
        // Empty queue: X seen and popped in the same cycle, only Y stored
        step(2'b11, 64'hA1, 64'hB2, 1, 1'b0);
        check("bypass_same_valid", 64'(smp_valid), 64'(2'b11));
        check("bypass_same_lane0", smp_d0, 64'hA1);
        idle();
        check("bypass_count", 64'(smp_cnt), 64'(1));
        check("bypass_head", smp_d0, 64'hB2);
        step(2'b00, '0, '0, 1, 1'b0);
`else
        // Empty queue: nothing visible until the cycle after the push
        step(2'b11, 64'hA1, 64'hB2, 0, 1'b0);
        check("latency_same_valid", 64'(smp_valid), 64'(0));
        idle();
        check("latency_count", 64'(smp_cnt), 64'(2));
        check("latency_head", smp_d0, 64'hA1);
        step(2'b00, '0, '0, 2, 1'b0);
`endif
        idle();
        check("end_count", 64'(smp_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
